cnt_seq_ctrl: RTL and testbench
===============================

CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 Parameter DIV, default 50, clock cycles per counter-enable tick, legal range 2..65535.
REQ-002 Parameter LIMIT, default 16'h0009, counter-chain value at which a run completes.
REQ-003 Port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  synchronous, active-low reset.
REQ-005 Port start  input  1  start/resume request, level sampled each clock.
REQ-006 Port stop  input  1  pause request, level sampled each clock.
REQ-007 Port preset  input  1  preset request, level sampled each clock.
REQ-008 Port q_in  input  16  current value of the cascaded 4 x 4-bit counter chain, Q of the least significant stage in q_in[3:0].
REQ-009 Port ce_out  output  1  one-cycle count-enable pulse to the chain's first-stage ce.
REQ-010 Port s_out  output  1  synchronous-set pulse to every stage's s, which drives the chain to 16'hFFFF.
REQ-011 Port busy  output  1  high in RUN or HOLD.
REQ-012 Port done  output  1  one-cycle completion pulse.
REQ-013 Port state  output  2  encoded FSM state for debug/LEDs.

Function
REQ-014 FSM states SHALL be IDLE=2'd0, RUN=2'd1, HOLD=2'd2, PRESET=2'd3, registered.
REQ-015 Request priority in every state SHALL be preset > stop > start.
REQ-016 IDLE: preset -> PRESET; else start -> RUN with prescaler cleared to 0; else stay.
REQ-017 RUN: preset -> PRESET; else stop -> HOLD; else q_in==LIMIT -> IDLE with done=1 in the transition cycle; else stay.
REQ-018 HOLD: preset -> PRESET; else start -> RUN with prescaler value retained; stop ignored.
REQ-019 PRESET: s_out=1 for exactly that one cycle; next state IDLE unconditionally.
REQ-020 Prescaler SHALL be a 16-bit counter 0..DIV-1, incrementing only while state==RUN, wrapping DIV-1 -> 0.
REQ-021 ce_out SHALL be combinationally high iff state==RUN, prescaler==DIV-1, and no preset, stop, or limit exit occurs that cycle.
REQ-022 Tick spacing in uninterrupted RUN SHALL be exactly DIV cycles; the first tick after IDLE->RUN SHALL occur DIV cycles after the transition edge.
REQ-023 The limit compare SHALL use q_in unregistered; LIMIT==16'hFFFF SHALL complete immediately after a preset-then-start.
REQ-024 done and s_out SHALL never be high in the same cycle, and neither SHALL be high in consecutive cycles.
REQ-025 A start held high across a done SHALL NOT restart until the cycle after done (IDLE is entered first).
REQ-026 Chain wrap 16'hFFFF->0 SHALL be treated as normal counting with no special action.

Reset
REQ-027 With rst_n==0 at a rising edge: state=IDLE, prescaler=0, and ce_out, s_out, busy, done all 0 from the next cycle.
REQ-028 Reset mid-RUN or mid-PRESET SHALL abort with no residual ce_out or s_out pulse; the counter-chain value is untouched.
REQ-029 Reset SHALL take precedence over all requests.

Structure
REQ-030 The state encoding constants and the LIMIT/DIV defaults SHALL live in shared package cnt_seq_pkg.
REQ-031 The prescaler SHALL be the sub-module tick_prescaler (ports clk, rst_n, en, clr, tick) instantiated once.
REQ-032 The counter stages SHALL NOT be instantiated inside this block; the chain is wired externally through CEO-to-ce cascading.

Verification (bench: DIV=4, LIMIT=16'h0003, behavioural 16-bit counter model on ce_out/s_out)
REQ-033 Reset then 1-cycle start -> ce_out pulses every 4 cycles; q_in reaches 3, then done=1 for one cycle, state=0, busy=0.
REQ-034 Stop after 2 cycles of the first RUN, HOLD for 10 cycles, then start -> no ce_out during HOLD; first tick 2 cycles after resume.
REQ-035 preset in RUN -> s_out=1 for one cycle, state 3->0, chain=16'hFFFF; next start, first tick wraps the chain to 0.
REQ-036 start, stop, and preset asserted together in IDLE -> PRESET; start and stop together in HOLD -> stays HOLD.
REQ-037 rst_n=0 one cycle before a due tick in RUN -> no ce_out, state=0, prescaler=0.
REQ-038 start held high continuously -> exactly one idle cycle between done and the next RUN entry.

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// Purpose : shared FSM state encoding and default parameters for the counter sequencer.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package cnt_seq_pkg;

  // Encoded controller state, also exported on the debug/LED port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_PRESET = 2'd3
  } state_t;

  // Clock cycles per count-enable tick (legal 2..65535).
  localparam int unsigned DIV_DEFAULT   = 50;
  // Chain value at which a run completes.
  localparam logic [15:0] LIMIT_DEFAULT = 16'h0009;

endpackage

// File: rtl/tick_prescaler.sv
// Purpose : free-running 0..DIV-1 prescaler that flags the terminal count while enabled.
// Latency : tick is combinational from the registered count; count advances one per enabled clock.
// Backpressure : none; en freezes the count in place, clr forces it to zero.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   en    - advance the count this cycle
//   clr   - synchronous clear (wins over en)
//   tick  - high while enabled and the count sits at DIV-1
module tick_prescaler
  import cnt_seq_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(DIV - 1);

  logic [15:0] r_cnt;
  logic        w_at_term;

  assign w_at_term = (r_cnt == TERM);
  assign tick      = en && w_at_term;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_term ? '0 : r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Purpose : run/hold/preset sequencer driving an external cascaded 4 x 4-bit counter chain.
// Latency : state, busy, done, s_out registered (1 cycle); ce_out combinational off the prescaler.
// Backpressure : none; requests are levels, priority preset > stop > start in every state.
//
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   start, stop, preset   - request levels sampled each clock
//   q_in[15:0]            - live chain value, least significant stage in [3:0]
//   ce_out                - one-cycle count enable into the first chain stage
//   s_out                 - one-cycle synchronous set (chain -> 16'hFFFF)
//   busy, done, state     - status: RUN/HOLD flag, completion pulse, encoded state
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int unsigned DIV   = DIV_DEFAULT,
  parameter logic [15:0] LIMIT = LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        preset,
  input  logic [15:0] q_in,
  output logic        ce_out,
  output logic        s_out,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state
);

  state_t r_state;
  logic   r_s_out;
  logic   r_busy;
  logic   r_done;

  logic   w_run;
  logic   w_at_limit;
  logic   w_tick;
  logic   w_pre_clr;

  assign w_run      = (r_state == ST_RUN);
  assign w_at_limit = (q_in == LIMIT);
  // Prescaler is zeroed whenever we are outside RUN/HOLD so a fresh run
  // always starts a full DIV period; HOLD leaves it untouched for resume.
  assign w_pre_clr  = (r_state == ST_IDLE) || (r_state == ST_PRESET);

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_run),
    .clr   (w_pre_clr),
    .tick  (w_tick)
  );

  // A tick coinciding with any RUN exit is swallowed so the chain never
  // counts on the same edge the controller leaves RUN.
  assign ce_out = w_tick && !preset && !stop && !w_at_limit;
  assign s_out  = r_s_out;
  assign busy   = r_busy;
  assign done   = r_done;
  assign state  = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_s_out <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_s_out <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (preset) begin
            r_state <= ST_PRESET;
            r_s_out <= 1'b1;
          end else if (start && !stop) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (preset) begin
            r_state <= ST_PRESET;
            r_s_out <= 1'b1;
            r_busy  <= 1'b0;
          end else if (stop) begin
            r_state <= ST_HOLD;
          end else if (w_at_limit) begin
            // done lands in the first IDLE cycle, so a held start can only
            // re-enter RUN on the edge after the pulse.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (preset) begin
            r_state <= ST_PRESET;
            r_s_out <= 1'b1;
            r_busy  <= 1'b0;
          end else if (start && !stop) begin
            r_state <= ST_RUN;
          end
        end
        ST_PRESET: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Purpose : directed self-checking bench for cnt_seq_ctrl with a behavioural 16-bit chain on ce_out/s_out.
// Latency : checks sampled 3 ns after each rising edge; inputs driven 2 ns after the edge.
// Backpressure : n/a.
module tb_cnt_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        preset;
  logic [15:0] chain = 16'h0000;
  logic        ce_out;
  logic        s_out;
  logic        busy;
  logic        done;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  cnt_seq_ctrl #(
    .DIV   (4),
    .LIMIT (16'h0003)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .preset (preset),
    .q_in   (chain),
    .ce_out (ce_out),
    .s_out  (s_out),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  always #5 clk = ~clk;

  // External counter chain: set wins over count enable; FFFF wraps to 0.
  always @(posedge clk) begin
    if (s_out)       chain <= 16'hFFFF;
    else if (ce_out) chain <= chain + 16'd1;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic st, input logic sp, input logic pr);
    start  = st;
    stop   = sp;
    preset = pr;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    preset = 1'b0;
    cyc();
    cyc();
    #1;
    // Reset state
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_busy",  16'(busy),  16'd0);
    chk("rst_ce",    16'(ce_out), 16'd0);
    chk("rst_s",     16'(s_out), 16'd0);
    chk("rst_done",  16'(done),  16'd0);
    chk("rst_pre",   dut.u_prescaler.r_cnt, 16'd0);

    // Basic run: one-cycle start, tick every 4 cycles, done at chain==3
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    for (int j = 0; j <= 12; j++) begin
      chk("t1_ce",    16'(ce_out), 16'(j % 4 == 3));
      chk("t1_state", 16'(state),  16'd1);
      cyc();
    end
    chk("t1_chain", chain,        16'd3);
    chk("t1_done",  16'(done),    16'd1);
    chk("t1_state_idle", 16'(state), 16'd0);
    chk("t1_busy",  16'(busy),    16'd0);
    cyc();
    chk("t1_done_off", 16'(done), 16'd0);

    // Preset from IDLE, then run, stop after 2 RUN cycles, hold 10, resume
    drive(1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    chk("t2_pre_state", 16'(state), 16'd3);
    chk("t2_pre_s",     16'(s_out), 16'd1);
    cyc();
    chk("t2_s_off",  16'(s_out), 16'd0);
    chk("t2_chain",  chain,      16'hFFFF);
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    chk("t2_run0", 16'(state), 16'd1);
    cyc();
    drive(1'b0, 1'b1, 1'b0);
    chk("t2_run1_ce", 16'(ce_out), 16'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 10; h++) begin
      chk("t2_hold_state", 16'(state),  16'd2);
      chk("t2_hold_ce",    16'(ce_out), 16'd0);
      chk("t2_hold_busy",  16'(busy),   16'd1);
      if (h == 9) drive(1'b1, 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("t2_resume_state", 16'(state),  16'd1);
    chk("t2_resume_ce0",   16'(ce_out), 16'd0);
    cyc();
    chk("t2_resume_ce1",   16'(ce_out), 16'd1);
    cyc();
    chk("t2_wrap_chain",   chain,       16'h0000);
    chk("t2_wrap_ce",      16'(ce_out), 16'd0);

    // Preset in RUN on a due tick: tick suppressed, one s_out pulse
    cyc();
    cyc();
    cyc();
    drive(1'b0, 1'b0, 1'b1);
    chk("t3_pre_ce",    16'(ce_out), 16'd0);
    chk("t3_pre_run",   16'(state),  16'd1);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    chk("t3_state3",    16'(state),  16'd3);
    chk("t3_s_on",      16'(s_out),  16'd1);
    chk("t3_busy",      16'(busy),   16'd0);
    chk("t3_done",      16'(done),   16'd0);
    chk("t3_chain_hold", chain,      16'h0000);
    cyc();
    chk("t3_state0",    16'(state),  16'd0);
    chk("t3_s_off",     16'(s_out),  16'd0);
    chk("t3_chain_set", chain,       16'hFFFF);
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    cyc();
    chk("t3_first_tick", 16'(ce_out), 16'd1);
    cyc();
    chk("t3_chain_wrap", chain,       16'h0000);

    // Reset one cycle before a due tick
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    cyc();
    chk("t4_rst_ce",    16'(ce_out), 16'd0);
    chk("t4_rst_state", 16'(state),  16'd0);
    chk("t4_rst_busy",  16'(busy),   16'd0);
    chk("t4_rst_s",     16'(s_out),  16'd0);
    chk("t4_rst_pre",   dut.u_prescaler.r_cnt, 16'd0);
    chk("t4_rst_chain", chain,       16'h0000);
    rst_n = 1'b1;
    #1;
    cyc();
    chk("t4_post_ce",   16'(ce_out), 16'd0);
    chk("t4_post_state", 16'(state), 16'd0);

    // All three requests in IDLE -> PRESET; start+stop in HOLD stays HOLD
    drive(1'b1, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    chk("t5_all_state", 16'(state), 16'd3);
    chk("t5_all_s",     16'(s_out), 16'd1);
    cyc();
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b0);
    chk("t5_hold",      16'(state), 16'd2);
    cyc();
    chk("t5_hold_kept", 16'(state), 16'd2);

    // Start held continuously through a completion
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    chk("t6_run", 16'(state), 16'd1);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!found) begin
        cyc();
        if (done === 1'b1) found = 1'b1;
      end
    end
    chk("t6_done_seen",  16'(found), 16'd1);
    chk("t6_idle_state", 16'(state), 16'd0);
    chk("t6_idle_busy",  16'(busy),  16'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    chk("t6_rerun_state", 16'(state), 16'd1);
    chk("t6_rerun_done",  16'(done),  16'd0);
    cyc();
    chk("t6_redone",      16'(done),  16'd1);
    chk("t6_redone_state", 16'(state), 16'd0);
    cyc();
    chk("t6_done_single", 16'(done),  16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
